// File: rtl/input_debounce.sv
// Debounces a raw asynchronous input: 2-flop synchroniser, stability FSM,
// registered level with rise/fall pulses and a saturating glitch counter.
module input_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt,
  input  logic                glitch_clr
);

  typedef enum logic [1:0] {
    LOW,
    CHK_HIGH,
    HIGH,
    CHK_LOW
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic                s1_q, s2_q;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dout_q, dout_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_ev = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = CHK_HIGH;
          cnt_d   = ONE;
        end
      end
      CHK_HIGH: begin
        if (!s2_q) begin
          state_d   = LOW;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = CHK_LOW;
          cnt_d   = ONE;
        end
      end
      CHK_LOW: begin
        if (s2_q) begin
          state_d   = HIGH;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // The level follows the next state so dout and its pulse land together.
  always_comb begin
    dout_d = (state_d == HIGH) || (state_d == CHK_LOW);
  end

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr)
      glitch_d = '0;
    else if (glitch_ev && (glitch_q != '1))
      glitch_d = glitch_q + GLITCH_W'(1);
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: latency, glitch filtering,
// threshold, bounce, counter saturation/clear and async reset.
module tb_input_debounce;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       dout, rise, fall;
  logic [7:0] gcnt;
  logic       gclr;

  logic       din_g;
  logic       dout_g, rise_g, fall_g;
  logic [1:0] gcnt_g;
  logic       gclr_g;

  int n_chk  = 0;
  int n_pass = 0;

  input_debounce #(.STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (gcnt),
    .glitch_clr (gclr)
  );

  input_debounce #(.STABLE_CYCLES(SC), .GLITCH_W(2)) dut_g (
    .clk        (clk),
    .rst        (rst),
    .din        (din_g),
    .dout       (dout_g),
    .rise       (rise_g),
    .fall       (fall_g),
    .glitch_cnt (gcnt_g),
    .glitch_clr (gclr_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int nr, nf, nboth, g0;

  initial begin
    rst    = 1'b1;
    din    = 1'b0;
    gclr   = 1'b0;
    din_g  = 1'b0;
    gclr_g = 1'b0;

    // reset and clean step
    tick(3);
    chk("rst_dout", dout, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_gcnt", gcnt, 0);
    rst = 1'b0;
    din = 1'b1;
    nr  = 0;
    for (int e = 0; e <= 4; e++) begin
      tick(1);
      if (dout || rise) nr++;
    end
    chk("step_early", nr, 0);
    tick(1);
    chk("step_dout", dout, 1);
    chk("step_rise", rise, 1);
    tick(1);
    chk("step_rise_off", rise, 0);
    chk("step_hold", dout, 1);

    // return low: fall lands after the same latency
    din = 1'b0;
    tick(5);
    chk("rel_early", dout, 1);
    tick(1);
    chk("rel_dout", dout, 0);
    chk("rel_fall", fall, 1);
    tick(1);
    chk("rel_fall_off", fall, 0);
    tick(3);

    // short glitch: 2 samples high
    din = 1'b1;
    tick(2);
    din = 1'b0;
    nr  = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (rise || dout) nr++;
    end
    chk("short_norise", nr, 0);
    chk("short_gcnt", gcnt, 1);

    // exact threshold: 4 samples high
    gclr = 1'b1;
    tick(1);
    gclr = 1'b0;
    chk("clr_gcnt", gcnt, 0);
    din = 1'b1;
    tick(SC);
    din   = 1'b0;
    nr    = 0;
    nf    = 0;
    nboth = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (rise) nr++;
      if (fall) nf++;
      if (rise && fall) nboth++;
    end
    chk("exact_rise", nr, 1);
    chk("exact_fall", nf, 1);
    chk("exact_both", nboth, 0);
    chk("exact_dout", dout, 0);
    chk("exact_gcnt", gcnt, 0);

    // bounce on release with two aborted low checks
    din = 1'b1;
    tick(10);
    chk("bnc_start", dout, 1);
    g0 = int'(gcnt);
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      din = (i < 5) ? ~i[0] : 1'b0;
      tick(1);
      if (fall) nf++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (fall) nf++;
    end
    chk("bnc_gcnt", gcnt, 32'(g0 + 2));
    chk("bnc_fall", nf, 1);
    chk("bnc_dout", dout, 0);

    // saturation on the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      din_g = 1'b1;
      tick(2);
      din_g = 1'b0;
      tick(6);
    end
    chk("sat_gcnt", gcnt_g, 3);
    chk("sat_dout", dout_g, 0);
    // clear coincides with the glitch edge
    din_g = 1'b1;
    tick(2);
    din_g = 1'b0;
    tick(2);
    chk("pre_clr", gcnt_g, 3);
    gclr_g = 1'b1;
    tick(1);
    gclr_g = 1'b0;
    chk("clr_prio", gcnt_g, 0);
    tick(1);
    chk("clr_stay", gcnt_g, 0);

    // async reset while checking high
    din = 1'b1;
    tick(4);
    chk("mid_cnt", dut.cnt_q, 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cnt", dut.cnt_q, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_rise", rise, 0);
    tick(2);
    chk("mid_hold_rise", rise, 0);
    rst = 1'b0;
    nr  = 0;
    for (int e = 0; e <= 4; e++) begin
      tick(1);
      if (dout || rise) nr++;
    end
    chk("mid_relat", nr, 0);
    tick(1);
    chk("mid_dout", dout, 1);
    chk("mid_rise", rise, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
